// File: rtl/gmii_tx_arb_pkg.sv
// Shared definitions for the two-requester GMII transmit arbiter.
// Holds the arbiter state encoding, the default timing/length parameters,
// the counter widths and the byte/enable/error beat carried through the mux.
package gmii_tx_arb_pkg;

    localparam int unsigned IFG_LEN_DEF  = 12;
    localparam int unsigned START_TO_DEF = 16;
    localparam int unsigned MAX_LEN_DEF  = 1536;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned BYTE_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XMIT  = 2'd2,
        ST_IFG   = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] txd;
        logic              en;
        logic              er;
    } gmii_beat_t;

endpackage

// File: rtl/gmii_tx_mux.sv
// Registered 2:1 GMII byte/enable/error mux.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   pass               forward the selected requester this cycle
//   sel_b              0 selects requester A, 1 selects requester B
//   force_er           OR-ed into the forwarded TX_ER
//   txd_*/en_*/er_*    requester byte, enable and error
//   sel_en_c           combinational enable of the selected requester
//   txd, tx_en, tx_er  registered GMII outputs
module gmii_tx_mux
    import gmii_tx_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pass,
    input  logic              sel_b,
    input  logic              force_er,
    input  logic [DATA_W-1:0] txd_a,
    input  logic [DATA_W-1:0] txd_b,
    input  logic              en_a,
    input  logic              en_b,
    input  logic              er_a,
    input  logic              er_b,
    output logic              sel_en_c,
    output logic [DATA_W-1:0] txd,
    output logic              tx_en,
    output logic              tx_er
);

    gmii_beat_t beat_c;
    gmii_beat_t beat_q;

    assign sel_en_c = sel_b ? en_b : en_a;

    // Only an enabled byte of the selected requester is forwarded; all else is zero.
    always_comb begin
        beat_c = '0;
        if (pass && sel_en_c) begin
            beat_c.en  = 1'b1;
            beat_c.txd = sel_b ? txd_b : txd_a;
            beat_c.er  = (sel_b ? er_b : er_a) | force_er;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_c;
        end
    end

    assign txd   = beat_q.txd;
    assign tx_en = beat_q.en;
    assign tx_er = beat_q.er;

endmodule

// File: rtl/gmii_tx_arb.sv
// Round-robin arbiter sharing one GMII transmit port between requesters A and B.
// Ports:
//   GMII_TX_CLK, GMII_RSTn          clock, asynchronous active-low reset
//   REQ_A/B, GNT_A/B                frame request, registered one-hot grant
//   TXD_*, TX_EN_*, TX_ER_*         requester GMII streams
//   GMII_TXD/TX_EN/TX_ER            muxed stream, one cycle behind the granted input
//   ERR_LONG, ERR_TO                one-cycle pulses: over-length frame, start timeout
module gmii_tx_arb
    import gmii_tx_arb_pkg::*;
#(
    parameter int unsigned IFG_LEN  = IFG_LEN_DEF,
    parameter int unsigned START_TO = START_TO_DEF,
    parameter int unsigned MAX_LEN  = MAX_LEN_DEF
) (
    input  logic       GMII_TX_CLK,
    input  logic       GMII_RSTn,
    input  logic       REQ_A,
    input  logic       REQ_B,
    output logic       GNT_A,
    output logic       GNT_B,
    input  logic [7:0] TXD_A,
    input  logic [7:0] TXD_B,
    input  logic       TX_EN_A,
    input  logic       TX_EN_B,
    input  logic       TX_ER_A,
    input  logic       TX_ER_B,
    output logic [7:0] GMII_TXD,
    output logic       GMII_TX_EN,
    output logic       GMII_TX_ER,
    output logic       ERR_LONG,
    output logic       ERR_TO
);

    localparam int unsigned CMP_W = BYTE_W + 1;
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_LEN - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(START_TO - 1);
    localparam logic [CMP_W-1:0] LEN_LIM  = CMP_W'(MAX_LEN);

    arb_state_t        state_q, state_d;
    logic              gnt_a_q, gnt_a_d;
    logic              gnt_b_q, gnt_b_d;
    logic              last_b_q, last_b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
    logic              long_q, long_d;
    logic              err_long_q, err_long_d;
    logic              err_to_q, err_to_d;

    logic              pass_c;
    logic              sel_en_c;
    logic              en_c;
    logic              pick_b_c;
    logic [BYTE_W-1:0] byte_num_c;
    logic              force_er_c;

    assign pass_c   = (state_q == ST_GRANT) || (state_q == ST_XMIT);
    assign en_c     = pass_c && sel_en_c;
    // B wins when alone, or on a tie when A was served last.
    assign pick_b_c = REQ_B && (!REQ_A || !last_b_q);

    // Ordinal of the byte being accepted this cycle; saturates at the counter limit.
    assign byte_num_c = (state_q == ST_GRANT) ? BYTE_W'(1) :
                        (&byte_cnt_q)         ? byte_cnt_q :
                                                byte_cnt_q + BYTE_W'(1);

    // Once a frame goes over length, every later byte of it keeps TX_ER forced.
    assign force_er_c = en_c && (long_q || ({1'b0, byte_num_c} > LEN_LIM));

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        gnt_a_d    = gnt_a_q;
        gnt_b_d    = gnt_b_q;
        last_b_d   = last_b_q;
        cnt_d      = cnt_q;
        byte_cnt_d = byte_cnt_q;
        long_d     = long_q;
        err_long_d = 1'b0;
        err_to_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d      = '0;
                byte_cnt_d = '0;
                long_d     = 1'b0;
                if (REQ_A || REQ_B) begin
                    gnt_a_d = !pick_b_c;
                    gnt_b_d = pick_b_c;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (en_c) begin
                    byte_cnt_d = byte_num_c;
                    long_d     = force_er_c;
                    err_long_d = force_er_c;
                    cnt_d      = '0;
                    state_d    = ST_XMIT;
                end else if (cnt_q == TO_LAST) begin
                    gnt_a_d  = 1'b0;
                    gnt_b_d  = 1'b0;
                    last_b_d = gnt_b_q;
                    err_to_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_IFG;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_XMIT: begin
                if (en_c) begin
                    byte_cnt_d = byte_num_c;
                    long_d     = long_q | force_er_c;
                    err_long_d = force_er_c && !long_q;
                end else begin
                    gnt_a_d  = 1'b0;
                    gnt_b_d  = 1'b0;
                    last_b_d = gnt_b_q;
                    cnt_d    = '0;
                    state_d  = ST_IFG;
                end
            end
            ST_IFG: begin
                if (cnt_q == IFG_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; last served resets to A.
    always_ff @(posedge GMII_TX_CLK or negedge GMII_RSTn) begin
        if (!GMII_RSTn) begin
            state_q    <= ST_IDLE;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            last_b_q   <= 1'b0;
            cnt_q      <= '0;
            byte_cnt_q <= '0;
            long_q     <= 1'b0;
            err_long_q <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_a_q    <= gnt_a_d;
            gnt_b_q    <= gnt_b_d;
            last_b_q   <= last_b_d;
            cnt_q      <= cnt_d;
            byte_cnt_q <= byte_cnt_d;
            long_q     <= long_d;
            err_long_q <= err_long_d;
            err_to_q   <= err_to_d;
        end
    end

    gmii_tx_mux u_mux (
        .clk      (GMII_TX_CLK),
        .rst_n    (GMII_RSTn),
        .pass     (pass_c),
        .sel_b    (gnt_b_q),
        .force_er (force_er_c),
        .txd_a    (TXD_A),
        .txd_b    (TXD_B),
        .en_a     (TX_EN_A),
        .en_b     (TX_EN_B),
        .er_a     (TX_ER_A),
        .er_b     (TX_ER_B),
        .sel_en_c (sel_en_c),
        .txd      (GMII_TXD),
        .tx_en    (GMII_TX_EN),
        .tx_er    (GMII_TX_ER)
    );

    assign GNT_A    = gnt_a_q;
    assign GNT_B    = gnt_b_q;
    assign ERR_LONG = err_long_q;
    assign ERR_TO   = err_to_q;

endmodule

// File: tb/tb_gmii_tx_arb.sv
// Directed bench for gmii_tx_arb: reset, round-robin, single frames with IFG,
// start timeout, over-length frame and mid-frame reset. Requesters are modelled
// by a driver that sends frames when granted and drives random noise otherwise.
module tb_gmii_tx_arb;

    localparam int unsigned IFG  = 12;
    localparam int unsigned STO  = 16;
    localparam int unsigned MLEN = 64;

    logic       clk;
    logic       rst_n;
    logic       req_s  [2];
    logic [7:0] txd_s  [2];
    logic       en_s   [2];
    logic       er_s   [2];
    logic       gnt_a, gnt_b;
    logic [7:0] gtxd;
    logic       gen, ger;
    logic       err_long, err_to;

    // Frame configuration written only by the test sequence.
    int         len_cfg    [2];
    logic [7:0] base_cfg   [2];
    int         frames_req [2];
    int         holds_req  [2];
    // Requester state written only by the driver.
    int         frames_done [2];
    int         holds_done  [2];
    int         idx         [2];
    bit         prev_g      [2];
    bit         held        [2];

    // Monitor records.
    logic [8:0] out_q[$];
    int         grant_q[$];
    int         err_long_at[$];
    int         err_to_cnt;
    int         both_cnt;
    int         zero_viol;
    bit         pa, pb;

    int n_checks;
    int n_pass;

    gmii_tx_arb #(.IFG_LEN(IFG), .START_TO(STO), .MAX_LEN(MLEN)) dut (
        .GMII_TX_CLK (clk),
        .GMII_RSTn   (rst_n),
        .REQ_A       (req_s[0]),
        .REQ_B       (req_s[1]),
        .GNT_A       (gnt_a),
        .GNT_B       (gnt_b),
        .TXD_A       (txd_s[0]),
        .TXD_B       (txd_s[1]),
        .TX_EN_A     (en_s[0]),
        .TX_EN_B     (en_s[1]),
        .TX_ER_A     (er_s[0]),
        .TX_ER_B     (er_s[1]),
        .GMII_TXD    (gtxd),
        .GMII_TX_EN  (gen),
        .GMII_TX_ER  (ger),
        .ERR_LONG    (err_long),
        .ERR_TO      (err_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester model: frame bytes base+i while granted, noise while not granted.
    initial begin : driver
        for (int s = 0; s < 2; s++) begin
            frames_done[s] = 0; holds_done[s] = 0; idx[s] = 0;
            prev_g[s] = 1'b0; held[s] = 1'b0;
            req_s[s] = 1'b0; txd_s[s] = 8'h00; en_s[s] = 1'b0; er_s[s] = 1'b0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int s = 0; s < 2; s++) begin
                logic g;
                g = (s == 0) ? gnt_a : gnt_b;
                if (!rst_n) begin
                    idx[s] = 0; prev_g[s] = 1'b0; held[s] = 1'b0;
                    en_s[s] = 1'b0; txd_s[s] = 8'h00; er_s[s] = 1'b0;
                end else begin
                    if (g && !prev_g[s]) begin
                        idx[s]  = 0;
                        held[s] = holds_done[s] < holds_req[s];
                        if (held[s]) begin
                            holds_done[s]++;
                            frames_done[s]++;
                        end
                    end
                    prev_g[s] = g;
                    if (g && (held[s] || idx[s] >= len_cfg[s])) begin
                        en_s[s] = 1'b0; txd_s[s] = 8'($urandom); er_s[s] = 1'b0;
                    end else if (g) begin
                        en_s[s]  = 1'b1;
                        txd_s[s] = base_cfg[s] + 8'(idx[s]);
                        er_s[s]  = 1'b0;
                        idx[s]++;
                        if (idx[s] == len_cfg[s]) frames_done[s]++;
                    end else begin
                        en_s[s] = 1'($urandom); txd_s[s] = 8'($urandom); er_s[s] = 1'($urandom);
                    end
                end
                req_s[s] = frames_done[s] < frames_req[s];
            end
        end
    end

    // Output monitor, sampled on the falling edge.
    initial begin : monitor
        err_to_cnt = 0; both_cnt = 0; zero_viol = 0; pa = 1'b0; pb = 1'b0;
        forever begin
            @(negedge clk);
            if (gen) out_q.push_back({ger, gtxd});
            if (err_long) err_long_at.push_back(out_q.size());
            if (err_to) err_to_cnt++;
            if (gnt_a && !pa) grant_q.push_back(0);
            if (gnt_b && !pb) grant_q.push_back(1);
            pa = gnt_a;
            pb = gnt_b;
            if (gnt_a && gnt_b) both_cnt++;
            if (!gen && (gtxd != 8'h00 || ger)) zero_viol++;
        end
    end

    task automatic wait_done(input int budget, output bit ok);
        int n;
        n = 0;
        while (n < budget && (frames_done[0] < frames_req[0] || frames_done[1] < frames_req[1])) begin
            @(negedge clk);
            n++;
        end
        ok = (n < budget);
        repeat (25) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({gnt_a, gnt_b} !== 2'b00) $display("FAIL reset_gnt: got %b want 00", {gnt_a, gnt_b});
        else n_pass++;
        n_checks++;
        if ({gtxd, gen, ger} !== 10'h000) $display("FAIL reset_data: got txd=%h en=%b er=%b want 00/0/0", gtxd, gen, ger);
        else n_pass++;
        n_checks++;
        if ({err_long, err_to} !== 2'b00) $display("FAIL reset_err: got %b want 00", {err_long, err_to});
        else n_pass++;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({gnt_a, gnt_b} !== 2'b00) $display("FAIL idle_no_req: got gnt %b want 00", {gnt_a, gnt_b});
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int gq0, oq0, bad, k;
        bit ok;
        int exp_g[6];
        exp_g = '{1, 0, 1, 0, 1, 0};
        @(negedge clk);
        rst_n = 1'b0;
        len_cfg[0] = 10; base_cfg[0] = 8'h10;
        len_cfg[1] = 8;  base_cfg[1] = 8'hA0;
        frames_req[0] += 3;
        frames_req[1] += 3;
        repeat (2) @(negedge clk);
        #1;
        gq0 = grant_q.size();
        oq0 = out_q.size();
        rst_n = 1'b1;
        wait_done(3000, ok);
        n_checks++;
        if (!ok) $display("FAIL rr_done: frames not finished within budget");
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 6; i++)
            if (gq0 + i >= grant_q.size() || grant_q[gq0 + i] != exp_g[i]) bad++;
        n_checks++;
        if (bad !== 0 || grant_q.size() != gq0 + 6)
            $display("FAIL rr_order: %0d grant mismatches, %0d grants, want B,A,B,A,B,A", bad, grant_q.size() - gq0);
        else n_pass++;
        bad = 0;
        k = oq0;
        for (int f = 0; f < 6; f++) begin
            int s;
            s = exp_g[f];
            for (int i = 0; i < len_cfg[s]; i++) begin
                if (k >= out_q.size() || out_q[k] !== {1'b0, base_cfg[s] + 8'(i)}) bad++;
                k++;
            end
        end
        n_checks++;
        if (bad !== 0 || out_q.size() != oq0 + 54)
            $display("FAIL rr_data: %0d byte mismatches, %0d bytes, want 54", bad, out_q.size() - oq0);
        else n_pass++;
    endtask

    task automatic test_single_frame();
        int oq0, el0, n, tail, bad;
        int req_n, gnt_n, in_n, out_n, gap_start, gnt2_n;
        req_n = -1; gnt_n = -1; in_n = -1; out_n = -1; gap_start = -1; gnt2_n = -1;
        @(negedge clk);
        #1;
        oq0 = out_q.size();
        el0 = err_long_at.size();
        len_cfg[0] = 64; base_cfg[0] = 8'h55;
        frames_req[0] += 2;
        n = 0; tail = -1;
        while (n < 800 && tail != 0) begin
            @(negedge clk);
            if (req_n < 0 && req_s[0]) req_n = n;
            if (gnt_n < 0 && gnt_a) gnt_n = n;
            if (in_n < 0 && gnt_a && en_s[0]) in_n = n;
            if (out_n < 0 && gen) out_n = n;
            if (out_n >= 0 && gap_start < 0 && !gen) gap_start = n;
            if (gap_start >= 0 && gnt2_n < 0 && n > gap_start && gnt_a) gnt2_n = n;
            if (tail < 0 && frames_done[0] >= frames_req[0]) tail = 25;
            else if (tail > 0) tail--;
            n++;
        end
        #1;
        n_checks++;
        if (tail != 0) $display("FAIL single_done: frames not finished within budget");
        else n_pass++;
        n_checks++;
        if (gnt_n - req_n !== 1) $display("FAIL single_gnt_latency: got %0d cycles want 1", gnt_n - req_n);
        else n_pass++;
        n_checks++;
        if (out_n - in_n !== 1) $display("FAIL single_data_latency: got %0d cycles want 1", out_n - in_n);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 128; i++)
            if (oq0 + i >= out_q.size() || out_q[oq0 + i] !== {1'b0, 8'h55 + 8'(i % 64)}) bad++;
        n_checks++;
        if (bad !== 0 || out_q.size() != oq0 + 128)
            $display("FAIL single_data: %0d byte mismatches, %0d bytes, want 128", bad, out_q.size() - oq0);
        else n_pass++;
        // Idle gap: IFG_LEN cycles in IFG plus the IDLE arbitration cycle.
        n_checks++;
        if (gnt2_n - gap_start !== 13) $display("FAIL single_ifg_gap: got %0d cycles want 13", gnt2_n - gap_start);
        else n_pass++;
        n_checks++;
        if (err_long_at.size() !== el0) $display("FAIL single_no_long: got %0d ERR_LONG pulses want 0", err_long_at.size() - el0);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int oq0, gq0, to0, n, tail, bad, k;
        int b_start, b_end, to_n, a_n;
        int exp_g[3];
        exp_g = '{1, 0, 1};
        b_start = -1; b_end = -1; to_n = -1; a_n = -1;
        @(negedge clk);
        #1;
        oq0 = out_q.size(); gq0 = grant_q.size(); to0 = err_to_cnt;
        len_cfg[0] = 4; base_cfg[0] = 8'h20;
        len_cfg[1] = 6; base_cfg[1] = 8'hC0;
        holds_req[1] += 1;
        frames_req[1] += 2;
        frames_req[0] += 1;
        n = 0; tail = -1;
        while (n < 800 && tail != 0) begin
            @(negedge clk);
            if (b_start < 0 && gnt_b) b_start = n;
            if (b_start >= 0 && b_end < 0 && !gnt_b) b_end = n;
            if (to_n < 0 && err_to) to_n = n;
            if (a_n < 0 && gnt_a) a_n = n;
            if (tail < 0 && frames_done[0] >= frames_req[0] && frames_done[1] >= frames_req[1]) tail = 25;
            else if (tail > 0) tail--;
            n++;
        end
        #1;
        n_checks++;
        if (tail != 0) $display("FAIL to_done: frames not finished within budget");
        else n_pass++;
        n_checks++;
        if (b_end - b_start !== 16) $display("FAIL to_gnt_len: got %0d cycles want 16", b_end - b_start);
        else n_pass++;
        n_checks++;
        if (err_to_cnt - to0 !== 1 || to_n !== b_end)
            $display("FAIL to_pulse: got %0d pulses at cycle %0d want 1 at %0d", err_to_cnt - to0, to_n, b_end);
        else n_pass++;
        n_checks++;
        if (a_n - b_end !== 13) $display("FAIL to_ifg_gap: got %0d cycles want 13", a_n - b_end);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 3; i++)
            if (gq0 + i >= grant_q.size() || grant_q[gq0 + i] != exp_g[i]) bad++;
        n_checks++;
        if (bad !== 0 || grant_q.size() != gq0 + 3)
            $display("FAIL to_order: %0d grant mismatches, %0d grants, want B,A,B", bad, grant_q.size() - gq0);
        else n_pass++;
        bad = 0;
        k = oq0;
        for (int i = 0; i < 4; i++) begin if (k >= out_q.size() || out_q[k] !== {1'b0, 8'h20 + 8'(i)}) bad++; k++; end
        for (int i = 0; i < 6; i++) begin if (k >= out_q.size() || out_q[k] !== {1'b0, 8'hC0 + 8'(i)}) bad++; k++; end
        n_checks++;
        if (bad !== 0 || out_q.size() != oq0 + 10)
            $display("FAIL to_data: %0d byte mismatches, %0d bytes, want 10", bad, out_q.size() - oq0);
        else n_pass++;
    endtask

    task automatic test_long_frame();
        int oq0, el0, bad;
        bit ok;
        @(negedge clk);
        #1;
        oq0 = out_q.size();
        el0 = err_long_at.size();
        len_cfg[0] = 70; base_cfg[0] = 8'h00;
        frames_req[0] += 1;
        wait_done(1000, ok);
        n_checks++;
        if (!ok) $display("FAIL long_done: frame not finished within budget");
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 70; i++)
            if (oq0 + i >= out_q.size() || out_q[oq0 + i] !== {(i >= 64) ? 1'b1 : 1'b0, 8'(i)}) bad++;
        n_checks++;
        if (bad !== 0 || out_q.size() != oq0 + 70)
            $display("FAIL long_data_er: %0d byte mismatches, %0d bytes, want 70 with ER on 65..70", bad, out_q.size() - oq0);
        else n_pass++;
        n_checks++;
        if (err_long_at.size() - el0 !== 1) $display("FAIL long_pulse_cnt: got %0d pulses want 1", err_long_at.size() - el0);
        else n_pass++;
        n_checks++;
        if (err_long_at.size() > el0 && err_long_at[el0] !== oq0 + 65)
            $display("FAIL long_pulse_pos: got byte %0d want 65", err_long_at[el0] - oq0);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int oq0, oq1, gq1, n, bad;
        bit ok;
        @(negedge clk);
        #1;
        oq0 = out_q.size();
        len_cfg[0] = 40; base_cfg[0] = 8'h80;
        frames_req[0] += 1;
        n = 0;
        while (n < 300 && out_q.size() < oq0 + 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (n >= 300) $display("FAIL rst_reach_byte20: got %0d bytes want 20", out_q.size() - oq0);
        else n_pass++;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({gnt_a, gnt_b, gtxd, gen, ger, err_long, err_to} !== 14'h0000)
            $display("FAIL rst_async_zero: got gnt=%b%b txd=%h en=%b er=%b el=%b et=%b want all 0",
                     gnt_a, gnt_b, gtxd, gen, ger, err_long, err_to);
        else n_pass++;
        repeat (2) @(negedge clk);
        oq1 = out_q.size();
        gq1 = grant_q.size();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < oq1 - oq0; i++)
            if (out_q[oq0 + i] !== {1'b0, 8'h80 + 8'(i)}) bad++;
        n_checks++;
        if (bad !== 0 || oq1 != oq0 + 20)
            $display("FAIL rst_partial: %0d byte mismatches, %0d bytes, want 20 clean", bad, oq1 - oq0);
        else n_pass++;
        wait_done(1000, ok);
        n_checks++;
        if (!ok || grant_q.size() != gq1 + 1 || grant_q[gq1] != 0)
            $display("FAIL rst_regrant: done=%b grants=%0d want one A grant", ok, grant_q.size() - gq1);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 40; i++)
            if (oq1 + i >= out_q.size() || out_q[oq1 + i] !== {1'b0, 8'h80 + 8'(i)}) bad++;
        n_checks++;
        if (bad !== 0 || out_q.size() != oq1 + 40)
            $display("FAIL rst_full_frame: %0d byte mismatches, %0d bytes, want 40", bad, out_q.size() - oq1);
        else n_pass++;
    endtask

    task automatic test_isolation();
        n_checks++;
        if (both_cnt !== 0) $display("FAIL both_granted: got %0d cycles want 0", both_cnt);
        else n_pass++;
        n_checks++;
        if (zero_viol !== 0) $display("FAIL idle_outputs_zero: got %0d nonzero idle cycles want 0", zero_viol);
        else n_pass++;
    endtask

    initial begin : seq
        n_checks = 0;
        n_pass   = 0;
        for (int s = 0; s < 2; s++) begin
            len_cfg[s] = 0; base_cfg[s] = 8'h00; frames_req[s] = 0; holds_req[s] = 0;
        end
        rst_n = 1'b0;
        test_reset();
        test_round_robin();
        test_single_frame();
        test_timeout();
        test_long_frame();
        test_reset_mid_frame();
        test_isolation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
